if_fetch_unit: RTL and testbench



---
 rtl/fetch_pkg.sv | 15 +
 rtl/ifid_reg.sv | 44 ++++
 rtl/if_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_if_fetch_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    typedef enum logic [2:0] {
        ADDR = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        DROP = 3'd3,
        HOLD = 3'd4
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INST_C = 32'h0000_0013;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with flush > stall > load > bubble priority.
module ifid_reg
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(NOP_INST_C)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              stall,
    input  logic              load,
    input  logic [ADDR_W-1:0] load_pc,
    input  logic [DATA_W-1:0] load_inst,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic [DATA_W-1:0] ifid_inst,
    output logic              ifid_valid
);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (!rst) begin
            ifid_pc    <= '0;
            ifid_inst  <= NOP_INST;
            ifid_valid <= 1'b0;
        end else if (flush) begin
            ifid_inst  <= NOP_INST;
            ifid_valid <= 1'b0;
        end else if (stall) begin
            ifid_pc    <= ifid_pc;
        end else if (load) begin
            ifid_pc    <= load_pc;
            ifid_inst  <= load_inst;
            ifid_valid <= 1'b1;
        end else begin
            // Bubble: the PC is kept so debug views still show the last fetch.
            ifid_inst  <= NOP_INST;
            ifid_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch_unit.sv
// Fetch stage: one outstanding instruction-memory request, flush/kill handling,
// one-entry hold buffer for ID stalls. Optional counters under FETCH_PERF_CNT_EN.
module if_fetch_unit
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] NOP_INST = DATA_W'(NOP_INST_C)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] current_pc,
    input  logic              flush,
    input  logic              id_stall,
    input  logic              mul_stall,
    output logic              fetch_stall,
    output logic              im_req_valid,
    input  logic              im_req_ready,
    output logic [ADDR_W-1:0] im_req_addr,
    input  logic              im_rsp_valid,
    input  logic [DATA_W-1:0] im_rsp_data,
    output logic [ADDR_W-1:0] ifid_pc,
    output logic [DATA_W-1:0] ifid_inst,
    output logic              ifid_valid
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_drop_cnt
`endif
);

    fetch_state_e      state, state_next;
    logic [ADDR_W-1:0] req_addr, req_addr_next;
    logic [DATA_W-1:0] hold_data, hold_data_next;
    logic              kill, kill_next;
    logic              stall, load;
    logic [DATA_W-1:0] load_inst;

    assign stall        = id_stall | mul_stall;
    assign load         = ((state == WAIT && im_rsp_valid) || state == HOLD)
                          && !stall && !flush && !kill;
    assign load_inst    = (state == HOLD) ? hold_data : im_rsp_data;
    assign fetch_stall  = !load && !flush;
    assign im_req_valid = (state == REQ);
    assign im_req_addr  = req_addr;

    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        state_next     = state;
        req_addr_next  = req_addr;
        kill_next      = kill;
        hold_data_next = hold_data;
        unique case (state)
            ADDR: begin
                req_addr_next = current_pc;
                kill_next     = 1'b0;
                state_next    = REQ;
            end
            REQ: begin
                if (flush) kill_next = 1'b1;
                if (im_req_ready) state_next = (flush || kill) ? DROP : WAIT;
            end
            WAIT: begin
                if (flush) begin
                    state_next = im_rsp_valid ? ADDR : DROP;
                end else if (im_rsp_valid) begin
                    if (stall) begin
                        hold_data_next = im_rsp_data;
                        state_next     = HOLD;
                    end else begin
                        state_next = ADDR;
                    end
                end
            end
            HOLD: begin
                if (flush || !stall) state_next = ADDR;
            end
            DROP: begin
                // The wrong-path response still has to drain before reissuing.
                if (im_rsp_valid) begin
                    kill_next  = 1'b0;
                    state_next = ADDR;
                end
            end
            default: state_next = ADDR;
        endcase
    end

    // NOTE: hold_data is reset even though it is only read after being written;
    // it is a single word, and a known value keeps IF/ID traces clean.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ADDR;
            req_addr  <= '0;
            kill      <= 1'b0;
            hold_data <= '0;
        end else begin
            state     <= state_next;
            req_addr  <= req_addr_next;
            kill      <= kill_next;
            hold_data <= hold_data_next;
        end
    end

    ifid_reg #(
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .NOP_INST(NOP_INST)
    ) u_ifid_reg (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .stall     (stall),
        .load      (load),
        .load_pc   (req_addr),
        .load_inst (load_inst),
        .ifid_pc   (ifid_pc),
        .ifid_inst (ifid_inst),
        .ifid_valid(ifid_valid)
    );

`ifdef FETCH_PERF_CNT_EN
    logic drop_event;

    assign drop_event = (state == DROP && im_rsp_valid)
                     || (state == WAIT && flush && im_rsp_valid)
                     || (state == HOLD && flush);

    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_stall_cnt <= '0;
            perf_drop_cnt  <= '0;
        end else begin
            if (fetch_stall && !flush) perf_stall_cnt <= perf_stall_cnt + 32'd1;
            if (drop_event)            perf_drop_cnt  <= perf_drop_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed self-checking bench for if_fetch_unit.
module tb_if_fetch_unit;
    import fetch_pkg::*;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] current_pc;
    logic        flush, id_stall, mul_stall;
    logic        fetch_stall, im_req_valid, im_req_ready, im_rsp_valid;
    logic [31:0] im_req_addr, im_rsp_data;
    logic [31:0] ifid_pc, ifid_inst;
    logic        ifid_valid;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_stall_cnt, perf_drop_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    if_fetch_unit dut (
        .clk         (clk),
        .rst         (rst),
        .current_pc  (current_pc),
        .flush       (flush),
        .id_stall    (id_stall),
        .mul_stall   (mul_stall),
        .fetch_stall (fetch_stall),
        .im_req_valid(im_req_valid),
        .im_req_ready(im_req_ready),
        .im_req_addr (im_req_addr),
        .im_rsp_valid(im_rsp_valid),
        .im_rsp_data (im_rsp_data),
        .ifid_pc     (ifid_pc),
        .ifid_inst   (ifid_inst),
        .ifid_valid  (ifid_valid)
`ifdef FETCH_PERF_CNT_EN
        ,
        .perf_stall_cnt(perf_stall_cnt),
        .perf_drop_cnt (perf_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] pc,
                              input logic [31:0] inst, input logic valid);
        check({tag, ".pc"},    64'(ifid_pc),    64'(pc));
        check({tag, ".inst"},  64'(ifid_inst),  64'(inst));
        check({tag, ".valid"}, 64'(ifid_valid), 64'(valid));
    endtask

    initial begin
        rst = 1'b0; current_pc = 32'h0; flush = 1'b0; id_stall = 1'b0; mul_stall = 1'b0;
        im_req_ready = 1'b0; im_rsp_valid = 1'b0; im_rsp_data = 32'h0;

        // Reset, then a basic fetch from PC 0
        tick();
        check_ifid("reset", 32'h0, NOP, 1'b0);
        check("reset.req_valid", 64'(im_req_valid), 64'd0);
        check("reset.state", 64'(dut.state), 64'(ADDR));
        check("reset.fetch_stall", 64'(fetch_stall), 64'd1);
        rst = 1'b1; im_req_ready = 1'b1;
        tick();
        check("t1.req_valid", 64'(im_req_valid), 64'd1);
        check("t1.req_addr", 64'(im_req_addr), 64'h0);
        check("t1.fetch_stall_req", 64'(fetch_stall), 64'd1);
        tick();
        im_req_ready = 1'b0; im_rsp_valid = 1'b1; im_rsp_data = 32'h0050_0093;
        #1 check("t1.fetch_stall_load", 64'(fetch_stall), 64'd0);
        tick();
        im_rsp_valid = 1'b0;
        check_ifid("t1", 32'h0, 32'h0050_0093, 1'b1);
        check("t1.fetch_stall_after", 64'(fetch_stall), 64'd1);

        // Backpressure: ready low 4 cycles, address must stay put
        current_pc = 32'h10;
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t2.req_valid%0d", i), 64'(im_req_valid), 64'd1);
            check($sformatf("t2.req_addr%0d", i), 64'(im_req_addr), 64'h10);
            check($sformatf("t2.fetch_stall%0d", i), 64'(fetch_stall), 64'd1);
            if (i == 0) current_pc = 32'h14;
            tick();
        end
        im_req_ready = 1'b1;
        tick();
        im_req_ready = 1'b0;

        // Response arrives under id_stall -> HOLD, released after 2 cycles
        im_rsp_valid = 1'b1; im_rsp_data = 32'h0020_8133; id_stall = 1'b1;
        #1 check("t3.fetch_stall_stalled", 64'(fetch_stall), 64'd1);
        tick();
        im_rsp_valid = 1'b0;
        check("t3.state_hold0", 64'(dut.state), 64'(HOLD));
        check_ifid("t3.hold0", 32'h0, NOP, 1'b0);
        tick();
        check("t3.state_hold1", 64'(dut.state), 64'(HOLD));
        check_ifid("t3.hold1", 32'h0, NOP, 1'b0);
        id_stall = 1'b0;
        #1 check("t3.fetch_stall_release", 64'(fetch_stall), 64'd0);
        tick();
        check_ifid("t3.load", 32'h10, 32'h0020_8133, 1'b1);

        // mul_stall alone holds a valid IF/ID entry and forces HOLD
        current_pc = 32'h20; mul_stall = 1'b1; im_req_ready = 1'b1;
        tick();
        check_ifid("t3b.hold_valid", 32'h10, 32'h0020_8133, 1'b1);
        tick();
        im_req_ready = 1'b0; im_rsp_valid = 1'b1; im_rsp_data = 32'h0031_0233;
        #1 check("t3b.fetch_stall", 64'(fetch_stall), 64'd1);
        tick();
        im_rsp_valid = 1'b0;
        check("t3b.state_hold", 64'(dut.state), 64'(HOLD));
        check_ifid("t3b.still", 32'h10, 32'h0020_8133, 1'b1);
        mul_stall = 1'b0;
        tick();
        check_ifid("t3b.load", 32'h20, 32'h0031_0233, 1'b1);

        // Flush in REQ before ready -> response drained in DROP
        current_pc = 32'h24;
        tick();
        check_ifid("t4.bubble", 32'h20, NOP, 1'b0);
        flush = 1'b1;
        #1 check("t4.fetch_stall_flush", 64'(fetch_stall), 64'd0);
        tick();
        flush = 1'b0; current_pc = 32'h80; im_req_ready = 1'b1;
        tick();
        im_req_ready = 1'b0;
        check("t4.state_drop", 64'(dut.state), 64'(DROP));
        check("t4.req_valid_drop", 64'(im_req_valid), 64'd0);
        im_rsp_valid = 1'b1; im_rsp_data = 32'hDEAD_BEEF;
        #1 check("t4.fetch_stall_drop", 64'(fetch_stall), 64'd1);
        tick();
        im_rsp_valid = 1'b0;
        check_ifid("t4.discarded", 32'h20, NOP, 1'b0);
        tick();
        check("t4.req_addr_new", 64'(im_req_addr), 64'h80);
        check("t4.req_valid_new", 64'(im_req_valid), 64'd1);

        // Flush coincides with the response in WAIT
        im_req_ready = 1'b1;
        tick();
        im_req_ready = 1'b0; im_rsp_valid = 1'b1; im_rsp_data = 32'h0010_0093; flush = 1'b1;
        #1 check("t5.fetch_stall", 64'(fetch_stall), 64'd0);
        tick();
        flush = 1'b0; im_rsp_valid = 1'b0; current_pc = 32'h100;
        check_ifid("t5", 32'h20, NOP, 1'b0);
        check("t5.state", 64'(dut.state), 64'(ADDR));
`ifdef FETCH_PERF_CNT_EN
        check("t5.perf_drop", 64'(perf_drop_cnt), 64'd2);
`endif

        // Reset while in WAIT
        tick();
        im_req_ready = 1'b1;
        tick();
        im_req_ready = 1'b0; rst = 1'b0; current_pc = 32'h200;
        tick();
        check_ifid("t6.reset", 32'h0, NOP, 1'b0);
        check("t6.req_valid", 64'(im_req_valid), 64'd0);
        check("t6.state", 64'(dut.state), 64'(ADDR));
`ifdef FETCH_PERF_CNT_EN
        check("t6.perf_stall", 64'(perf_stall_cnt), 64'd0);
        check("t6.perf_drop", 64'(perf_drop_cnt), 64'd0);
`endif
        rst = 1'b1;
        tick();
        check("t6.req_addr", 64'(im_req_addr), 64'h200);
        check("t6.req_valid_new", 64'(im_req_valid), 64'd1);
        im_req_ready = 1'b1;
        tick();
        im_req_ready = 1'b0; im_rsp_valid = 1'b1; im_rsp_data = 32'h0000_0513;
        tick();
        im_rsp_valid = 1'b0;
        check_ifid("t6.load", 32'h200, 32'h0000_0513, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
